// File: rtl/rocc_resp_stage.sv
// rtl/rocc_resp_stage.sv - RoCC response stage: HLS result FIFO, response driver, in-flight counter
//
// Purpose: buffers 128-bit HLS OUT_r result words in a small FIFO and presents
// them on the RoCC response channel. Also tracks commands accepted but not yet
// answered (in_flight_count / rocc_busy), with sticky over/underflow flags.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   acc_out_valid/ready     HLS OUT_r stream handshake
//   acc_out_data[127:0]     rd in [4:0], data in [2*XLEN-1:XLEN]
//   cmd_fire                a RoCC command was accepted this cycle
//   rocc_resp_valid/ready   RoCC response handshake
//   rocc_resp_bits_rd/data  response payload
//   rocc_busy               in_flight_count != 0
//   in_flight_count         commands accepted but not yet responded
//   err_underflow           sticky: response fired with nothing in flight
//   err_overflow            sticky: in-flight counter saturated
//
// Build option: define ROCC_RESP_BYPASS_EN to present an arriving word on the
// response channel in the same cycle when the FIFO is empty.

module rocc_resp_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             acc_out_valid,
    output logic             acc_out_ready,
    input  logic [127:0]     acc_out_data,
    input  logic             cmd_fire,
    input  logic             rocc_resp_ready,
    output logic             rocc_resp_valid,
    output logic [4:0]       rocc_resp_bits_rd,
    output logic [XLEN-1:0]  rocc_resp_bits_data,
    output logic             rocc_busy,
    output logic [CNT_W-1:0] in_flight_count,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 5 + XLEN;
    localparam logic [AW:0]      OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     occ;
    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    logic            resp_fire;
    logic            byp_take;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign in_rd   = acc_out_data[4:0];
    assign in_data = acc_out_data[2*XLEN-1:XLEN];

    assign full  = (occ == OCC_FULL);
    assign empty = (occ == '0);

    // Strict full: no enqueue while full even if a dequeue happens this cycle.
    assign acc_out_ready = !full && !reset;

    // Head entry reads as zero when empty so the payload is clean after reset.
    assign head_rd   = empty ? 5'd0 : mem[rd_ptr][EW-1:XLEN];
    assign head_data = empty ? '0   : mem[rd_ptr][XLEN-1:0];

`ifdef ROCC_RESP_BYPASS_EN
    logic byp_sel;
    assign byp_sel             = empty && acc_out_valid && !reset;
    assign rocc_resp_valid     = !reset && (!empty || acc_out_valid);
    assign rocc_resp_bits_rd   = byp_sel ? in_rd   : head_rd;
    assign rocc_resp_bits_data = byp_sel ? in_data : head_data;
    // A bypassed word taken by the core is never written into the FIFO.
    assign byp_take            = byp_sel && rocc_resp_ready;
`else
    assign rocc_resp_valid     = !reset && !empty;
    assign rocc_resp_bits_rd   = head_rd;
    assign rocc_resp_bits_data = head_data;
    assign byp_take            = 1'b0;
`endif

    assign resp_fire = rocc_resp_valid && rocc_resp_ready;
    assign enq       = acc_out_valid && acc_out_ready && !byp_take;
    assign deq       = !empty && resp_fire;

    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr] <= {in_rd, in_data};
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight_count <= '0;
            err_underflow   <= 1'b0;
            err_overflow    <= 1'b0;
        end else if (cmd_fire && !resp_fire) begin
            if (in_flight_count == CNT_MAX) begin
                err_overflow <= 1'b1;
            end else begin
                in_flight_count <= in_flight_count + CNT_W'(1);
            end
        end else if (resp_fire && !cmd_fire) begin
            if (in_flight_count == '0) begin
                err_underflow <= 1'b1;
            end else begin
                in_flight_count <= in_flight_count - CNT_W'(1);
            end
        end
    end

    assign rocc_busy = (in_flight_count != '0);

endmodule

// File: tb/tb_rocc_resp_stage.sv
// tb/tb_rocc_resp_stage.sv - self-checking bench for rocc_resp_stage against a queue-based model

module tb_rocc_resp_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ROCC_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             acc_out_valid = 1'b0;
    logic             acc_out_ready;
    logic [127:0]     acc_out_data = '0;
    logic             cmd_fire = 1'b0;
    logic             rocc_resp_ready = 1'b0;
    logic             rocc_resp_valid;
    logic [4:0]       rocc_resp_bits_rd;
    logic [XLEN-1:0]  rocc_resp_bits_data;
    logic             rocc_busy;
    logic [CNT_W-1:0] in_flight_count;
    logic             err_underflow;
    logic             err_overflow;

    rocc_resp_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .acc_out_valid       (acc_out_valid),
        .acc_out_ready       (acc_out_ready),
        .acc_out_data        (acc_out_data),
        .cmd_fire            (cmd_fire),
        .rocc_resp_ready     (rocc_resp_ready),
        .rocc_resp_valid     (rocc_resp_valid),
        .rocc_resp_bits_rd   (rocc_resp_bits_rd),
        .rocc_resp_bits_data (rocc_resp_bits_data),
        .rocc_busy           (rocc_busy),
        .in_flight_count     (in_flight_count),
        .err_underflow       (err_underflow),
        .err_overflow        (err_overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending response words and the in-flight bookkeeping.
    logic [68:0] q[$];
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    logic [63:0] resp_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [4:0] rd, input logic [63:0] data);
        return {data, 59'd0, rd};
    endfunction

    // One cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic v, input logic [127:0] d, input logic c,
                        input logic rr, input logic rst);
        bit          e_valid;
        bit          e_ready;
        logic [68:0] e_word;
        bit          had;
        bit          rfire;
        bit          afire;
        @(negedge clock);
        acc_out_valid   = v;
        acc_out_data    = d;
        cmd_fire        = c;
        rocc_resp_ready = rr;
        reset           = rst;
        #1;
        had     = (q.size() > 0);
        e_ready = !rst && (q.size() < DEPTH);
        e_word  = '0;
        e_valid = 0;
        if (!rst) begin
            if (had) begin
                e_valid = 1;
                e_word  = q[0];
            end else if (BYP && v) begin
                e_valid = 1;
                e_word  = {d[4:0], d[127:64]};
            end
        end
        check("acc_out_ready", 64'(acc_out_ready), 64'(e_ready));
        check("resp_valid", 64'(rocc_resp_valid), 64'(e_valid));
        if (e_valid) begin
            check("resp_rd", 64'(rocc_resp_bits_rd), 64'(e_word[68:64]));
            check("resp_data", rocc_resp_bits_data, e_word[63:0]);
        end
        check("in_flight", 64'(in_flight_count), 64'(m_cnt));
        check("busy", 64'(rocc_busy), 64'(m_cnt != 0));
        check("err_ovf", 64'(err_overflow), 64'(m_ovf));
        check("err_unf", 64'(err_underflow), 64'(m_unf));
        if (rocc_resp_valid && rr) resp_log.push_back(rocc_resp_bits_data);

        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            rfire = e_valid && rr;
            afire = v && e_ready;
            if (rfire && had) void'(q.pop_front());
            if (afire && !(rfire && !had)) q.push_back({d[4:0], d[127:64]});
            if (c && !rfire) begin
                if (m_cnt == CMAX) m_ovf = 1; else m_cnt++;
            end else if (rfire && !c) begin
                if (m_cnt == 0) m_unf = 1; else m_cnt--;
            end
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, 1'b0, rr, 1'b0);
    endtask

    initial begin
        // Power-up reset: two edges with reset high before any comparison.
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);

        // Reset release state.
        idle(1'b0);
        check("rst_valid", 64'(rocc_resp_valid), 64'd0);
        check("rst_ready", 64'(acc_out_ready), 64'd1);
        check("rst_count", 64'(in_flight_count), 64'd0);

        // Single operation.
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        step(1'b1, mk(5'd10, 64'h0000_0000_DEAD_BEEF), 1'b0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Fill to full under back-pressure, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, mk(5'(i), 64'(i * 17)), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(5'd7, 64'h77), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap-around streaming with both sides ready.
        resp_log.delete();
        for (int i = 0; i < 10; i++) step(1'b1, mk(5'd3, 64'(i)), 1'b1, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        check("wrap_count", 64'(resp_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < resp_log.size(); i++) check("wrap_order", resp_log[i], 64'(i));

        // cmd_fire and resp_fire together with two in flight.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(5'd2, 64'h22), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("simul_count", 64'(in_flight_count), 64'd2);

        // Saturation of the in-flight counter.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("sat_count", 64'(in_flight_count), 64'(CMAX));
        check("sat_flag", 64'(err_overflow), 64'd1);

        // Underflow, then reset with buffered entries.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(5'd9, 64'h99), 1'b0, 1'b1, 1'b0);
        repeat (2) idle(1'b1);
        check("unf_flag", 64'(err_underflow), 64'd1);
        step(1'b1, mk(5'd4, 64'h44), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5'd5, 64'h55), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        resp_log.delete();
        repeat (3) idle(1'b1);
        check("rst_flush", 64'(resp_log.size()), 64'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1,
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rocc_resp_stage.md
Name: rocc_resp_stage

Overview:
- Downstream stage of the RoCC accelerator wrapper: consumes the 128-bit AXI-stream result word from the HLS TOP core (OUT_r) and buffers it in a small FIFO.
- Drives the RoCC response channel (rd, data) from the FIFO.
- Owns the in-flight command counter and rocc_busy, so the wrapper itself stays a thin packer.
- Decouples HLS back-pressure from core response stalls.

Parameters:
- XLEN, 64, RoCC data width; result data is taken from acc_out_data[2*XLEN-1:XLEN].
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 6, width of the in-flight counter.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- acc_out_valid  in  1  HLS OUT_r_TVALID.
- acc_out_ready  out  1  to HLS OUT_r_TREADY.
- acc_out_data  in  128  HLS OUT_r_TDATA; rd in [4:0], data in [2*XLEN-1:XLEN], other bits ignored.
- cmd_fire  in  1  rocc_cmd_valid && rocc_cmd_ready, from the wrapper.
- rocc_resp_ready  in  1  core accepts response.
- rocc_resp_valid  out  1  response available.
- rocc_resp_bits_rd  out  5  destination register.
- rocc_resp_bits_data  out  XLEN  result.
- rocc_busy  out  1  in_flight_count != 0.
- in_flight_count  out  CNT_W  commands accepted but not yet responded.
- err_underflow  out  1  sticky: response fired with zero in flight.
- err_overflow  out  1  sticky: in-flight counter saturated.

Behaviour:
- Reset, synchronous, active-high. On the next rising edge with reset=1:
  - FIFO pointers and occupancy are cleared.
  - in_flight_count is 0; err_underflow and err_overflow are 0.
  - rocc_resp_valid is 0; rocc_resp_bits_rd and rocc_resp_bits_data are 0.
- acc_out_ready is forced 0 while reset is high.
- Reset mid-operation discards all buffered entries. No response is emitted for them.
- FIFO:
  - Each entry holds {rd[4:0], data[XLEN-1:0]} extracted from acc_out_data.
  - Occupancy count ranges 0..DEPTH. Read and write pointers wrap modulo DEPTH.
  - acc_out_ready = !full && !reset. This is strict: no enqueue while full, even if a dequeue happens in the same cycle.
  - Enqueue on acc_out_valid && acc_out_ready.
  - Dequeue on rocc_resp_valid && rocc_resp_ready.
  - Simultaneous enqueue and dequeue (not full, not empty): occupancy unchanged, both pointers advance.
  - rocc_resp_valid = !empty. rd/data come from the read-pointer entry and stay stable while valid && !ready.
  - Latency without bypass: word accepted in cycle N appears on rocc_resp in cycle N+1 at the earliest.
  - Throughput: 1 word/cycle sustained when rocc_resp_ready is held high.
- In-flight counter, with resp_fire = rocc_resp_valid && rocc_resp_ready:
  - cmd_fire && resp_fire: unchanged.
  - cmd_fire only: +1. If already 2^CNT_W-1, hold at max and set err_overflow.
  - resp_fire only: -1. If already 0, hold at 0 and set err_underflow.
  - Neither: unchanged.
- rocc_busy is combinational from the registered in_flight_count.
- Sticky error flags clear only on reset.

Optional Feature:
- Macro: ROCC_RESP_BYPASS_EN.
- Defined: when the FIFO is empty and acc_out_valid is 1:
  - rocc_resp_valid=1 in the same cycle, with rd/data taken directly from acc_out_data (zero latency).
  - If rocc_resp_ready=1, the word is consumed and not enqueued (occupancy stays 0).
  - If rocc_resp_ready=0, the word is enqueued normally.
- Undefined: no combinational path from acc_out to rocc_resp; minimum latency is 1 cycle.
- In-flight counting and error behaviour are identical in both builds.

Test Plan:
- Reset check: assert reset 2 cycles, then release -> rocc_resp_valid=0, in_flight_count=0, rocc_busy=0, acc_out_ready=1, both err flags 0.
- Single op: cmd_fire pulse; 3 cycles later acc_out_data={64'h0000_0000_DEAD_BEEF, 59'b0, 5'd10} with valid, rocc_resp_ready=1 ->
  - Response rd=10, data=0xDEADBEEF one cycle later (same cycle with ROCC_RESP_BYPASS_EN).
  - in_flight_count goes 1 then 0; rocc_busy low after the response fires.
- Full/back-pressure: rocc_resp_ready=0, push 4 words with rd=1..4 ->
  - acc_out_ready=0 after the 4th push.
  - Raising ready drains rd=1,2,3,4 in order, one per cycle.
  - acc_out_ready returns to 1 the cycle after the first pop.
- Wrap-around: stream 10 words with data=i, i=0..9, both sides always ready -> 10 responses, data 0..9 in order, none dropped or duplicated.
- Simultaneous events: cmd_fire and resp_fire in the same cycle with in_flight_count=2 -> count stays 2. Separately, cmd_fire held for 64 cycles with no responses -> count saturates at 63 and err_overflow=1.
- Underflow and reset mid-op: response with in_flight_count=0 -> err_underflow=1 and count stays 0. Then fill 2 entries and assert reset -> FIFO empty, no responses emitted, err_underflow cleared.
